// File: rtl/pio_cmd_arb.sv
// Two-requester round-robin command arbiter for a PIO block. It registers one
// command onto the pio_* bus and routes action-3 read data back to its originator.
module pio_cmd_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [1:0]  a_mindex,
  input  logic [3:0]  a_action,
  input  logic [4:0]  a_index,
  input  logic [31:0] a_din,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [1:0]  b_mindex,
  input  logic [3:0]  b_action,
  input  logic [4:0]  b_index,
  input  logic [31:0] b_din,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [1:0]  pio_mindex,
  output logic [3:0]  pio_action,
  output logic [4:0]  pio_index,
  output logic [31:0] pio_din,
  input  logic [31:0] pio_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_e;

  localparam logic       GNT_A    = 1'b0;
  localparam logic       GNT_B    = 1'b1;
  localparam logic [3:0] ACT_READ = 4'd3;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [1:0]  pio_mindex_q, pio_mindex_d;
  logic [3:0]  pio_action_q, pio_action_d;
  logic [4:0]  pio_index_q, pio_index_d;
  logic [31:0] pio_din_q, pio_din_d;
  logic        a_rvalid_q, a_rvalid_d;
  logic        b_rvalid_q, b_rvalid_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;

  logic        sel_b;
  logic        accept;
  logic [3:0]  win_action;

  // B wins when it is the only requester, or on contention when A was served last.
  assign sel_b = b_valid & (~a_valid | (last_grant_q == GNT_A));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    pio_mindex_d = pio_mindex_q;
    pio_action_d = 4'd0;
    pio_index_d  = pio_index_q;
    pio_din_d    = pio_din_q;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    accept       = 1'b0;
    win_action   = sel_b ? b_action : a_action;

    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so it drops the instant reset asserts, yet a
        // handshake is still possible on the very first edge after release.
        a_ready = reset & a_valid & ~sel_b;
        b_ready = reset & sel_b;
        accept  = a_ready | b_ready;
        if (accept) begin
          last_grant_d = sel_b ? GNT_B : GNT_A;
          owner_d      = sel_b;
          pio_mindex_d = sel_b ? b_mindex : a_mindex;
          pio_index_d  = sel_b ? b_index  : a_index;
          pio_din_d    = sel_b ? b_din    : a_din;
          pio_action_d = win_action;
          if (win_action != 4'd0) state_d = ISSUE;
        end
      end
      ISSUE: state_d = (pio_action_q == ACT_READ) ? RWAIT : IDLE;
      RWAIT: begin
        if (owner_q) begin
          b_rdata_d  = pio_dout;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = pio_dout;
          a_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_B;
      owner_q      <= 1'b0;
      pio_mindex_q <= '0;
      pio_action_q <= '0;
      pio_index_q  <= '0;
      pio_din_q    <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      pio_mindex_q <= pio_mindex_d;
      pio_action_q <= pio_action_d;
      pio_index_q  <= pio_index_d;
      pio_din_q    <= pio_din_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign pio_mindex = pio_mindex_q;
  assign pio_action = pio_action_q;
  assign pio_index  = pio_index_q;
  assign pio_din    = pio_din_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_pio_cmd_arb.sv
// Directed bench for pio_cmd_arb: a per-cycle vector table followed by a
// hand-written reset-during-read sequence.
module tb_pio_cmd_arb;

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [1:0]  a_mindex, b_mindex;
  logic [3:0]  a_action, b_action;
  logic [4:0]  a_index, b_index;
  logic [31:0] a_din, b_din;
  logic        a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  pio_mindex;
  logic [3:0]  pio_action;
  logic [4:0]  pio_index;
  logic [31:0] pio_din;
  logic [31:0] pio_dout;

  pio_cmd_arb dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_mindex(a_mindex), .a_action(a_action),
    .a_index(a_index), .a_din(a_din), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_mindex(b_mindex), .b_action(b_action),
    .b_index(b_index), .b_din(b_din), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .pio_mindex(pio_mindex), .pio_action(pio_action), .pio_index(pio_index),
    .pio_din(pio_din), .pio_dout(pio_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock cycle: inputs driven during the cycle, outputs expected in it.
  typedef struct {
    logic        av;  logic [3:0] aa; logic [4:0] ai; logic [31:0] ad; logic [1:0] am;
    logic        bv;  logic [3:0] ba; logic [4:0] bi; logic [31:0] bd; logic [1:0] bm;
    logic [31:0] dout;
    logic [1:0]  rdy;    // {a_ready, b_ready}
    logic [42:0] pio;    // {action, index, din, mindex}
    logic [1:0]  rv;     // {a_rvalid, b_rvalid}
    logic [63:0] rdata;  // {a_rdata, b_rdata}
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [42:0] p(input logic [3:0] act, input logic [4:0] idx,
                                    input logic [31:0] din, input logic [1:0] m);
    return {act, idx, din, m};
  endfunction

  task automatic add(input logic av, input logic [3:0] aa, input logic [4:0] ai,
                     input logic [31:0] ad, input logic [1:0] am,
                     input logic bv, input logic [3:0] ba, input logic [4:0] bi,
                     input logic [31:0] bd, input logic [1:0] bm,
                     input logic [31:0] dout, input logic [1:0] rdy,
                     input logic [42:0] pio, input logic [1:0] rv,
                     input logic [63:0] rdata);
    tbl.push_back('{av, aa, ai, ad, am, bv, ba, bi, bd, bm, dout, rdy, pio, rv, rdata});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_valid = v.av; a_action = v.aa; a_index = v.ai; a_din = v.ad; a_mindex = v.am;
    b_valid = v.bv; b_action = v.ba; b_index = v.bi; b_din = v.bd; b_mindex = v.bm;
    pio_dout = v.dout;
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] rdy,
                               input logic [42:0] pio, input logic [1:0] rv,
                               input logic [63:0] rdata);
    check({tag, " ready"}, 64'({a_ready, b_ready}), 64'(rdy));
    check({tag, " pio"},   64'({pio_action, pio_index, pio_din, pio_mindex}), 64'(pio));
    check({tag, " rvalid"}, 64'({a_rvalid, b_rvalid}), 64'(rv));
    check({tag, " rdata"}, {a_rdata, b_rdata}, rdata);
  endtask

  localparam logic [31:0] X = 32'h1111_1111;

  initial begin
    // A single command, then a no-op followed by action 6.
    add(1,4'd1,5'd5,32'h1234,2'd1, 0,0,0,0,0, 0, 2'b10, p(0,0,0,0),             2'b00, 64'h0);
    add(0,0,0,0,0,               0,0,0,0,0, 0, 2'b00, p(1,5,32'h1234,1),      2'b00, 64'h0);
    add(1,4'd0,5'd5,32'h1234,2'd1, 0,0,0,0,0, 0, 2'b10, p(0,5,32'h1234,1),    2'b00, 64'h0);
    add(1,4'd6,5'd3,32'h66,2'd2, 0,0,0,0,0, 0, 2'b10, p(0,5,32'h1234,1),      2'b00, 64'h0);
    // Continuous contention with action 4; last grant was A, so B goes first.
    add(1,4'd4,5'd7,32'hA0,2'd0, 1,4'd4,5'd9,32'hB0,2'd3, 0, 2'b00, p(6,3,32'h66,1'b0 ? 0 : 2), 2'b00, 64'h0);
    add(1,4'd4,5'd7,32'hA0,2'd0, 1,4'd4,5'd9,32'hB0,2'd3, 0, 2'b01, p(0,3,32'h66,2), 2'b00, 64'h0);
    add(1,4'd4,5'd7,32'hA0,2'd0, 1,4'd4,5'd9,32'hB0,2'd3, 0, 2'b00, p(4,9,32'hB0,3), 2'b00, 64'h0);
    add(1,4'd4,5'd7,32'hA0,2'd0, 1,4'd4,5'd9,32'hB0,2'd3, 0, 2'b10, p(0,9,32'hB0,3), 2'b00, 64'h0);
    add(1,4'd4,5'd7,32'hA0,2'd0, 1,4'd4,5'd9,32'hB0,2'd3, 0, 2'b00, p(4,7,32'hA0,0), 2'b00, 64'h0);
    add(1,4'd4,5'd7,32'hA0,2'd0, 1,4'd4,5'd9,32'hB0,2'd3, 0, 2'b01, p(0,7,32'hA0,0), 2'b00, 64'h0);
    add(0,0,0,0,0,               0,0,0,0,0, 0, 2'b00, p(4,9,32'hB0,3),         2'b00, 64'h0);
    // B read with A waiting; A is accepted in the cycle b_rvalid pulses.
    add(0,0,0,0,0, 1,4'd3,5'd1,32'h0,2'd2, 0,             2'b01, p(0,9,32'hB0,3), 2'b00, 64'h0);
    add(0,0,0,0,0, 0,0,0,0,0,              X,             2'b00, p(3,1,32'h0,2),  2'b00, 64'h0);
    add(1,4'd2,5'd4,32'h55,2'd1, 0,0,0,0,0, 32'hDEADBEEF, 2'b00, p(0,1,32'h0,2),  2'b00, 64'h0);
    add(1,4'd2,5'd4,32'h55,2'd1, 0,0,0,0,0, 0,            2'b10, p(0,1,32'h0,2),  2'b01, 64'h0000_0000_DEAD_BEEF);
    add(0,0,0,0,0, 0,0,0,0,0,              0,             2'b00, p(2,4,32'h55,1), 2'b00, 64'h0000_0000_DEAD_BEEF);
    // A read; B's rdata must hold.
    add(1,4'd3,5'd2,32'h0,2'd0, 0,0,0,0,0, 0,             2'b10, p(0,4,32'h55,1), 2'b00, 64'h0000_0000_DEAD_BEEF);
    add(0,0,0,0,0, 0,0,0,0,0,              X,             2'b00, p(3,2,32'h0,0),  2'b00, 64'h0000_0000_DEAD_BEEF);
    add(0,0,0,0,0, 0,0,0,0,0,              32'hCAFEF00D,  2'b00, p(0,2,32'h0,0),  2'b00, 64'h0000_0000_DEAD_BEEF);
    add(0,0,0,0,0, 0,0,0,0,0,              0,             2'b00, p(0,2,32'h0,0),  2'b10, 64'hCAFEF00D_DEADBEEF);
    add(0,0,0,0,0, 0,0,0,0,0,              0,             2'b00, p(0,2,32'h0,0),  2'b00, 64'hCAFEF00D_DEADBEEF);

    reset = 1'b0;
    drive('{default: '0});
    #1;
    check_outputs("reset", 2'b00, p(0,0,0,0), 2'b00, 64'h0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i].rdy, tbl[i].pio, tbl[i].rv, tbl[i].rdata);
      @(negedge clk);
    end

    // A read aborted by reset in RWAIT; last grant is A when reset hits.
    drive('{default: '0});
    a_valid = 1'b1; a_action = 4'd3; a_index = 5'd1;
    #1;
    check("abort accept", 64'({a_ready, b_ready}), 64'(2'b10));
    @(negedge clk);
    drive('{default: '0});
    #1;
    check("abort issue", 64'(pio_action), 64'(4'd3));
    @(negedge clk);
    pio_dout = 32'h5A5A_5A5A;
    a_valid = 1'b1; b_valid = 1'b1; a_action = 4'd1; b_action = 4'd1;
    #1;
    reset = 1'b0;
    #1;
    check_outputs("async reset", 2'b00, p(0,0,0,0), 2'b00, 64'h0);
    @(negedge clk);
    check_outputs("held reset", 2'b00, p(0,0,0,0), 2'b00, 64'h0);
    drive('{default: '0});
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("no rvalid %0d", i), 64'({a_rvalid, b_rvalid, a_rdata}), 64'h0);
      @(negedge clk);
    end
    a_valid = 1'b1; b_valid = 1'b1; a_action = 4'd1; b_action = 4'd1;
    a_index = 5'd8; b_index = 5'd2;
    #1;
    check("post reset grant", 64'({a_ready, b_ready}), 64'(2'b10));
    @(negedge clk);
    drive('{default: '0});
    #1;
    check("post reset pio", 64'({pio_action, pio_index}), 64'({4'd1, 5'd8}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
